// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: one code table used by both the encoder and the decoder.
// Patterns are normalised (1 = segment lit) and ordered g..a (bit6 = g, bit0 = a).
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic MODE_CC = 1'b1;
  localparam logic MODE_CA = 1'b0;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } seg_state_e;

endpackage

// File: rtl/seg_lut.sv
// Combinational reverse lookup: normalised segment pattern -> hex digit plus legal/blank flags.
module seg_lut
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       legal,
  output logic       is_blank
);

  always_comb begin
    digit = 4'h0;
    legal = 1'b1;
    case (pattern)
      SEG_0:   digit = 4'h0;
      SEG_1:   digit = 4'h1;
      SEG_2:   digit = 4'h2;
      SEG_3:   digit = 4'h3;
      SEG_4:   digit = 4'h4;
      SEG_5:   digit = 4'h5;
      SEG_6:   digit = 4'h6;
      SEG_7:   digit = 4'h7;
      SEG_8:   digit = 4'h8;
      SEG_9:   digit = 4'h9;
      SEG_A:   digit = 4'hA;
      SEG_B:   digit = 4'hB;
      SEG_C:   digit = 4'hC;
      SEG_D:   digit = 4'hD;
      SEG_E:   digit = 4'hE;
      SEG_F:   digit = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  assign is_blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seg_decoder.sv
// Recovers a hex digit from a raw 7-segment bus once the pattern has been stable
// for STABLE_CYCLES cycles after capture; reports legal, illegal or blank patterns.
module seg_decoder
  import seg_pkg::*;
#(
  parameter  int STABLE_CYCLES = 4,
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic [6:0] seg_in,
  output logic [3:0] hex_out,
  output logic       valid,
  output logic       err,
  output logic       blank,
  output logic       state_dbg
);

  // valid/err are single-cycle pulses with no ready: each stable episode produces at
  // most one of them, in the cycle the settle count completes; they are never high together.
  seg_state_e       state_q;
  logic [6:0]       sample_q;
  logic [6:0]       norm_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       hex_q;
  logic             valid_q;
  logic             err_q;
  logic             blank_q;

  logic [3:0]       lut_digit;
  logic             lut_legal;
  logic             lut_blank;

  // A mode flip inverts norm_d, so it naturally restarts settling like any pattern change.
  assign norm_d = (mode == MODE_CC) ? seg_in : ~seg_in;

  seg_lut u_lut (
    .pattern  (sample_q),
    .digit    (lut_digit),
    .legal    (lut_legal),
    .is_blank (lut_blank)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOCKED;
      sample_q <= 7'b0;
      cnt_q    <= '0;
      hex_q    <= 4'h0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      blank_q  <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (norm_d != sample_q) begin
        sample_q <= norm_d;
        cnt_q    <= '0;
        state_q  <= SETTLE;
      end else if (state_q == SETTLE) begin
        if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_q <= LOCKED;
          if (lut_legal) begin
            hex_q   <= lut_digit;
            valid_q <= 1'b1;
            blank_q <= 1'b0;
          end else if (lut_blank) begin
            blank_q <= 1'b1;
          end else begin
            err_q   <= 1'b1;
            blank_q <= 1'b0;
          end
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign hex_out   = hex_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign blank     = blank_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_seg_decoder.sv
// Bench for seg_decoder: drives hold-episodes of segment patterns and checks decode events and levels.
module tb_seg_decoder;

  localparam int SC = 4;
  localparam logic [1:0] K_VALID = 2'd1;
  localparam logic [1:0] K_ERR   = 2'd2;
  localparam int W = 22;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [6:0] seg_in;
  logic [3:0] hex_out;
  logic       valid;
  logic       err;
  logic       blank;
  logic       state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  logic [6:0]   last_norm = 7'b0;
  int           ep_cap    = 0;
  bit           ep_done   = 1'b1;
  logic [3:0]   exp_hex   = 4'h0;
  logic         exp_blank = 1'b1;

  logic [6:0] codes [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seg_decoder #(.STABLE_CYCLES(SC)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .seg_in    (seg_in),
    .hex_out   (hex_out),
    .valid     (valid),
    .err       (err),
    .blank     (blank),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] pack_ev(input int c, input logic [1:0] k, input logic [3:0] h);
    logic [31:0] cv;
    cv = c;
    return {cv[15:0], k, h};
  endfunction

  function automatic bit ref_lookup(input logic [6:0] p, output logic [3:0] d);
    d = 4'h0;
    for (int i = 0; i < 16; i++)
      if (codes[i] == p) begin
        d = 4'(i);
        return 1'b1;
      end
    return 1'b0;
  endfunction

  // driver: called at a negedge, holds the pattern for n rising edges
  task automatic drive(input logic m, input logic [6:0] s, input int n);
    logic [6:0] nm;
    logic [3:0] d;
    int end_edge;
    mode   = m;
    seg_in = s;
    nm = m ? s : ~s;
    if (nm != last_norm) begin
      last_norm = nm;
      ep_cap    = cyc + 1;
      ep_done   = 1'b0;
    end
    end_edge = cyc + n;
    if (!ep_done && (ep_cap + SC <= end_edge)) begin
      ep_done = 1'b1;
      if (nm == 7'b0) begin
        exp_blank = 1'b1;
      end else if (ref_lookup(nm, d)) begin
        exp_hex   = d;
        exp_blank = 1'b0;
        exp_q.push_back(pack_ev(ep_cap + SC, K_VALID, d));
      end else begin
        exp_blank = 1'b0;
        exp_q.push_back(pack_ev(ep_cap + SC, K_ERR, exp_hex));
      end
    end
    repeat (n) @(negedge clk);
    check_eq("hex_lvl", {28'b0, hex_out}, {28'b0, exp_hex});
    check_eq("blank_lvl", {31'b0, blank}, {31'b0, exp_blank});
  endtask

  task automatic model_reset();
    last_norm = 7'b0;
    ep_done   = 1'b1;
    exp_hex   = 4'h0;
    exp_blank = 1'b1;
  endtask

  // scoreboard: every pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (valid || err) begin
      check_eq("excl", {31'b0, valid & err}, 32'd0);
      if (exp_q.size() == 0) begin
        check_eq("spurious", {30'b0, valid, err}, 32'd0);
      end else begin
        check_eq("event", {10'b0, pack_ev(cyc, valid ? K_VALID : K_ERR, hex_out)},
                 {10'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst    = 1'b1;
    mode   = 1'b1;
    seg_in = 7'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_hex", {28'b0, hex_out}, 32'h0);
    check_eq("rst_valid", {31'b0, valid}, 32'd0);
    check_eq("rst_err", {31'b0, err}, 32'd0);
    check_eq("rst_blank", {31'b0, blank}, 32'd1);
    check_eq("rst_state", {31'b0, state_dbg}, 32'd1);
    rst = 1'b0;

    drive(1'b1, 7'b1011011, 8);                 // 2
    drive(1'b0, 7'b0001000, 8);                 // A in common-anode
    drive(1'b1, 7'b0001000, 8);                 // mode flip -> illegal
    drive(1'b1, 7'b0000110, 2);                 // too short
    drive(1'b1, 7'b1001111, 8);                 // 3
    drive(1'b1, 7'b1101101, 8);                 // 5
    drive(1'b1, 7'b0000001, 8);                 // illegal
    drive(1'b1, 7'b0000000, 8);                 // blank
    check_eq("blank_state", {31'b0, state_dbg}, 32'd1);
    drive(1'b1, 7'b0111111, 8);                 // 0
    drive(1'b1, 7'b1001111, 6);                 // 3, glitch, 3 again
    drive(1'b1, 7'b1111111, 1);
    drive(1'b1, 7'b1001111, 6);
    drive(1'b1, 7'b1001111, 10);                // held: no further report

    // reset mid-settle
    drive(1'b1, 7'b1111111, 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_hex", {28'b0, hex_out}, 32'h0);
    check_eq("mid_rst_blank", {31'b0, blank}, 32'd1);
    check_eq("mid_rst_pulse", {30'b0, valid, err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(1'b1, 7'b1111111, 8);                 // 8

    // random episodes, some legal, some garbage, random polarity
    for (int i = 0; i < 60; i++) begin
      logic       m;
      logic [6:0] p;
      m = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) p = codes[$urandom_range(0, 15)];
      else                           p = 7'($urandom_range(0, 127));
      drive(m, m ? p : ~p, $urandom_range(1, 7));
    end
    drive(1'b1, 7'b1110001, 8);                 // F

    repeat (SC + 2) @(negedge clk);
    check_eq("q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_decoder.md
Name: seg_decoder

Overview:
- Receive-side counterpart of the hex-to-7-segment driver: samples a raw 7-segment pattern and recovers the 4-bit hex value.
- Used for loopback checking of display drivers and for reading segment buses from external modules.
- Normalises common-cathode/common-anode polarity, waits for the pattern to be stable for a programmable number of cycles, then emits a one-cycle decode result with legal/illegal status.

Parameters:
- STABLE_CYCLES, 4, consecutive cycles the normalised pattern must hold after capture before it is decoded (legal range >= 1).
- CNT_W, $clog2(STABLE_CYCLES+1), width of the settle counter (derived, not overridden).

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- mode  input  1  1: common cathode (segment on = 1); 0: common anode (segment on = 0)
- seg_in  input  7  raw segment pattern, bit0=a … bit6=g
- hex_out  output  4  last legally decoded hex digit
- valid  output  1  one-cycle pulse: new legal digit on hex_out
- err  output  1  one-cycle pulse: stable pattern is not one of the 16 legal codes
- blank  output  1  level: last stable pattern had all segments off

Behaviour:
- Reset (async, rst=1): state=LOCKED, sample_q=7'b0, cnt=0, hex_out=4'h0, valid=0, err=0, blank=1.
- Normalisation (combinational): norm = mode ? seg_in : ~seg_in.
  - A mode toggle changes norm, so it is handled as an ordinary pattern change.
- States: SETTLE, LOCKED. Actions on each rising edge, in priority order:
  1. If norm != sample_q: sample_q<=norm, cnt<=0, state<=SETTLE. This has priority in any state and restarts settling mid-count.
  2. Else if state==SETTLE and cnt==STABLE_CYCLES-1: state<=LOCKED and decode sample_q:
     - legal code: hex_out<=digit, valid<=1, blank<=0.
     - 7'b0: blank<=1, no valid, no err, hex_out held.
     - any other value: err<=1, blank<=0, hex_out held.
  3. Else if state==SETTLE: cnt<=cnt+1.
  4. LOCKED with no change: idle.
- valid and err are 0 in every cycle other than the decode cycle. They are never high together.
- Latency:
  - Pattern captured at edge k; valid/err visible after edge k+STABLE_CYCLES.
  - Example: STABLE_CYCLES=4 gives 4 cycles after capture.
- Repetition:
  - One report per stable episode.
  - The same pattern returning after any different pattern (including a 1-cycle glitch) is reported again.
  - A pattern held indefinitely is reported once.
- Legal codes (normalised, g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, B=1111100
  - C=0111001, D=1011110, E=1111001, F=1110001
- Reset mid-SETTLE: outputs go to reset values immediately and no pending pulse is issued.
  - After release, the first edge captures any non-zero norm, which is reported after STABLE_CYCLES as normal.
- seg_in is synchronous to clk. No metastability synchroniser is inside the block.

Decomposition:
- Shared package seg_pkg:
  - 16 segment-code constants (SEG_0..SEG_F), SEG_BLANK=7'b0.
  - polarity constants MODE_CC=1, MODE_CA=0.
  - state enum {SETTLE, LOCKED}.
- Encoder and decoder both import seg_pkg so the code table exists once.
- One sub-module, seg_lut:
  - combinational, input pattern[6:0], outputs digit[3:0], legal, is_blank.
  - instanced once on sample_q.

Test Plan:
- Reset, mode=1, seg_in=7'b1011011 held 8 cycles -> exactly one valid pulse 4 cycles after capture edge, hex_out=4'h2, err=0, blank=0.
- mode=0, seg_in=7'b0001000 held -> single valid, hex_out=4'hA. Then hold seg_in and toggle mode to 1 -> norm=7'b0001000 illegal -> err pulse, hex_out stays 4'hA.
- mode=1, seg_in=7'b0000110 for 2 cycles then 7'b1001111 held -> no pulse for the "1" pattern, single valid with hex_out=4'h3.
- Legal 7'b1101101 then 7'b0000001 held -> valid (5), then err pulse after 4 cycles, valid stays 0, hex_out remains 4'h5.
- seg_in=7'b0 (mode=1) held -> blank=1, valid=err=0. Then 7'b0111111 -> valid, hex_out=4'h0, blank=0.
- seg_in=7'b1111111 captured, rst pulsed 2 cycles after capture -> outputs at reset values during rst, no pulse. After release, valid with hex_out=4'h8 exactly 4 cycles after the first post-reset capture edge.
